// File: rtl/m_div_iter.sv
// rtl/m_div_iter.sv - iterative restoring unsigned divider, one quotient bit per clock
module m_div_iter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cal,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             fin,
    output logic             busy,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] dvd_r, dvs_r, quo_r;
    logic [WIDTH:0]   rem_r;
    logic [CW-1:0]    cnt;

    logic [WIDTH:0]   shifted, trial;
    logic [WIDTH+1:0] diff;
    logic             q_bit, zero_div, last, complete;

    logic             fin_d, busy_d, dz_d;
    logic [WIDTH-1:0] quo_d, rem_d;

    // One restoring step: shift in the next dividend bit, keep the difference if it fits.
    always_comb begin
        shifted  = {rem_r[WIDTH-1:0], dvd_r[WIDTH-1]};
        diff     = {1'b0, shifted} - {2'b00, dvs_r};
        q_bit    = ~diff[WIDTH+1];
        trial    = q_bit ? diff[WIDTH:0] : shifted;
        zero_div = (dvs_r == '0);
        last     = (cnt == CW'(WIDTH - 1));
        complete = (state == S_RUN) && (zero_div || last);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Completion wins over a simultaneous cal drop; DONE then leaves on the next edge.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (cal) state_nx = S_RUN;
            S_RUN: begin
                if (complete)  state_nx = S_DONE;
                else if (!cal) state_nx = S_IDLE;
            end
            S_DONE:  if (!cal) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        fin_d  = complete;
        busy_d = (state_nx == S_RUN);
        quo_d  = quotient;
        rem_d  = remainder;
        dz_d   = div_zero;
        if (complete) begin
            if (zero_div) begin
                quo_d = '1;
                rem_d = dvd_r;
                dz_d  = 1'b1;
            end else begin
                quo_d = {quo_r[WIDTH-2:0], q_bit};
                rem_d = trial[WIDTH-1:0];
                dz_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dvd_r     <= '0;
            dvs_r     <= '0;
            quo_r     <= '0;
            rem_r     <= '0;
            cnt       <= '0;
            fin       <= 1'b0;
            busy      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
        end else begin
            fin       <= fin_d;
            busy      <= busy_d;
            quotient  <= quo_d;
            remainder <= rem_d;
            div_zero  <= dz_d;
            if (state == S_IDLE && cal) begin
                dvd_r <= dividend;
                dvs_r <= divisor;
                quo_r <= '0;
                rem_r <= '0;
                cnt   <= '0;
            end else if (state == S_RUN && (cal || complete)) begin
                dvd_r <= {dvd_r[WIDTH-2:0], 1'b0};
                quo_r <= {quo_r[WIDTH-2:0], q_bit};
                rem_r <= trial;
                cnt   <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_m_div_iter.sv
// tb/tb_m_div_iter.sv - self-checking bench for m_div_iter against an arithmetic divide model
module tb_m_div_iter;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         cal;
    logic [W-1:0] dividend, divisor;
    logic         fin, busy, div_zero;
    logic [W-1:0] quotient, remainder;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q, exp_r;
    logic         exp_z;

    m_div_iter #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .cal(cal),
        .dividend(dividend), .divisor(divisor),
        .fin(fin), .busy(busy),
        .quotient(quotient), .remainder(remainder), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference result from plain arithmetic; a zero divisor saturates the quotient.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b);
        if (b == 0) begin
            exp_q = '1;
            exp_r = a;
            exp_z = 1'b1;
        end else begin
            exp_q = a / b;
            exp_r = a % b;
            exp_z = 1'b0;
        end
    endtask

    // Accept, wait for fin, hold cal for 'tail' cycles after fin, then drop cal for one edge.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input int tail,
                         input bit full);
        int lat;
        int busy_cnt;
        int extra_fin;
        logic [W-1:0] prev_q, prev_r;
        prev_q = quotient;
        prev_r = remainder;
        model(a, b);
        dividend = a;
        divisor  = b;
        cal      = 1'b1;
        tick();
        if (full) begin
            check("accept_q_held", 32'(quotient), 32'(prev_q));
            check("accept_r_held", 32'(remainder), 32'(prev_r));
            check("accept_fin", 32'(fin), 32'd0);
        end
        dividend = $urandom;
        divisor  = $urandom;
        busy_cnt = busy ? 1 : 0;
        lat = 0;
        while (!fin && lat < 40) begin
            tick();
            lat++;
            if (!fin && busy) busy_cnt++;
        end
        check("latency", 32'(lat), (b == 0) ? 32'd1 : 32'd16);
        check("quotient", 32'(quotient), 32'(exp_q));
        check("remainder", 32'(remainder), 32'(exp_r));
        check("div_zero", 32'(div_zero), 32'(exp_z));
        if (b != 0) begin
            check("identity", 32'(quotient) * 32'(b) + 32'(remainder), 32'(a));
            check("rem_lt_div", 32'(remainder < b), 32'd1);
        end
        if (full) begin
            check("busy_cycles", 32'(busy_cnt), (b == 0) ? 32'd1 : 32'd16);
            check("busy_at_fin", 32'(busy), 32'd0);
        end
        extra_fin = 0;
        for (int i = 0; i < tail; i++) begin
            tick();
            if (fin) extra_fin++;
            if (full) begin
                check("tail_q_held", 32'(quotient), 32'(exp_q));
                check("tail_r_held", 32'(remainder), 32'(exp_r));
            end
        end
        cal = 1'b0;
        tick();
        if (fin) extra_fin++;
        check("single_fin", 32'(extra_fin), 32'd0);
    endtask

    initial begin
        int fin_seen;
        logic [W-1:0] a, b;

        reset = 1'b1;
        cal = 1'b0;
        dividend = '0;
        divisor = '0;
        repeat (2) tick();
        check("rst_fin", 32'(fin), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_q", 32'(quotient), 32'd0);
        check("rst_r", 32'(remainder), 32'd0);
        check("rst_dz", 32'(div_zero), 32'd0);
        reset = 1'b0;
        tick();

        do_op(16'd100, 16'd7, 2, 1'b1);
        do_op(16'hFFFF, 16'd1, 0, 1'b1);
        do_op(16'd5, 16'd9, 1, 1'b1);
        do_op(16'd1234, 16'd0, 2, 1'b1);
        do_op(16'd40000, 16'd300, 3, 1'b1);
        do_op(16'd777, 16'd777, 0, 1'b1);

        // Abort: cal dropped on the 8th iteration edge.
        dividend = 16'd999;
        divisor  = 16'd3;
        cal = 1'b1;
        tick();
        repeat (7) tick();
        check("abort_busy_pre", 32'(busy), 32'd1);
        cal = 1'b0;
        tick();
        check("abort_busy", 32'(busy), 32'd0);
        fin_seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (fin) fin_seen++;
            tick();
        end
        check("abort_no_fin", 32'(fin_seen), 32'd0);
        check("abort_q_held", 32'(quotient), 32'(exp_q));
        check("abort_r_held", 32'(remainder), 32'(exp_r));

        // Asynchronous reset in the middle of the 5th iteration.
        dividend = 16'd5000;
        divisor  = 16'd13;
        cal = 1'b1;
        tick();
        repeat (5) tick();
        #2 reset = 1'b1;
        #1;
        check("areset_q", 32'(quotient), 32'd0);
        check("areset_r", 32'(remainder), 32'd0);
        check("areset_busy", 32'(busy), 32'd0);
        check("areset_fin", 32'(fin), 32'd0);
        repeat (2) tick();
        reset = 1'b0;
        cal = 1'b0;
        fin_seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (fin) fin_seen++;
        end
        check("areset_no_fin", 32'(fin_seen), 32'd0);
        check("areset_dz", 32'(div_zero), 32'd0);

        // Back-to-back ops as the controller issues them: two-cycle cal tail after fin.
        for (int n = 0; n < 50; n++) begin
            a = 16'($urandom);
            if (n % 4 == 0) b = 16'($urandom_range(1, 15));
            else            b = 16'($urandom_range(1, 65535));
            do_op(a, b, 2, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/m_div_iter.md
Name: m_div_iter

Overview:
- Iterative restoring unsigned divider that forms the datapath stage directly downstream of the calculation controller.
- Consumes the controller's registered `cal` enable and returns a one-cycle `fin` pulse when the result is ready.
- Produces one quotient bit per clock, so a full divide takes WIDTH iterations.
- Results are held stable after `fin` until the next accepted operation.

Parameters:
- WIDTH, 16, operand/result width in bits (≥2); also the iteration count.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- cal  input  1  calculation enable from controller; level-sensitive.
- dividend  input  WIDTH  unsigned dividend; sampled only on operation accept.
- divisor  input  WIDTH  unsigned divisor; sampled only on operation accept.
- fin  output  1  registered done pulse, high exactly one cycle per completed operation.
- busy  output  1  high while iterating (RUN state).
- quotient  output  WIDTH  result quotient; registered, held between operations.
- remainder  output  WIDTH  result remainder; registered, held between operations.
- div_zero  output  1  set with `fin` when the latched divisor was 0; held with results.

Behaviour:
- Reset (async, any time, including mid-operation): state=IDLE, iteration counter=0, internal operand/partial-remainder registers=0; outputs fin=0, busy=0, quotient=0, remainder=0, div_zero=0. No `fin` is produced for an operation interrupted by reset.
- States: IDLE, RUN, DONE.
- IDLE:
  - Edge A with cal=1 is the accept edge. It latches dividend and divisor, clears the partial remainder (WIDTH+1 bits) and counter, and moves to RUN.
  - Outputs are unchanged at edge A.
  - If divisor=0 at accept, go to a one-iteration zero path instead; see below.
  - With cal=0, stay in IDLE.
- RUN, one restoring step per edge:
  - Shift the partial remainder left and shift in the current dividend MSB.
  - Shift the dividend register left.
  - Trial-subtract the divisor. If the result is non-negative, keep the difference and shift a 1 into the quotient register; otherwise keep the shifted value and shift in a 0.
  - Increment the counter. The counter is $clog2(WIDTH)+1 bits wide and never wraps during an operation.
  - busy=1 throughout RUN.
- Completion: at edge A+WIDTH (the WIDTH-th step), move to DONE.
  - Register fin=1, busy=0, quotient, remainder[WIDTH-1:0], div_zero=0.
  - At edge A+WIDTH+1, fin returns to 0 regardless of cal.
  - Latency from accept edge to fin high is WIDTH edges.
- Divide by zero:
  - Edge A latches the operands and enters RUN.
  - At edge A+1, move to DONE with fin=1, quotient={WIDTH{1'b1}}, remainder=latched dividend, div_zero=1.
- DONE:
  - Results are held. Because the controller's `cal` is registered from its state, cal stays high for 1–2 cycles after fin.
  - Stay in DONE while cal=1; no re-accept and no second fin.
  - On the first edge with cal=0, go to IDLE.
  - A new operation requires cal to be observed low, then high again.
- Abort: cal=0 sampled in RUN moves to IDLE on that edge, with busy=0 and no fin. Output registers keep their previous values.
- Simultaneous events: reset dominates everything. In RUN, completion and cal=0 on the same edge resolves as completion (fin=1, go to DONE); DONE then exits on the next edge because cal is low.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- WIDTH=16, dividend=100, divisor=7, cal held high from accept edge -> fin high for exactly one cycle 16 edges after accept; quotient=14, remainder=2, div_zero=0; busy high for 16 cycles before fin.
- dividend=16'hFFFF, divisor=1; then dividend=5, divisor=9 (cal dropped and re-raised between ops) -> first op gives q=16'hFFFF, r=0; second gives q=0, r=5; exactly one fin per op.
- dividend=1234, divisor=0 -> fin one edge after accept; quotient=16'hFFFF, remainder=1234, div_zero=1.
- cal held high for 3 cycles after fin -> no second fin and no change to quotient/remainder; after cal goes low for one cycle and high again, a new op runs with fin 16 edges later.
- cal deasserted at iteration 8, and separately reset asserted asynchronously at iteration 5 -> abort: no fin, outputs keep the prior result. Reset: all outputs 0 immediately, no fin.
- Back-to-back driven by the controller model (cal registered from state, 2-cycle tail after fin) over 50 random operand pairs with nonzero divisor -> each quotient*divisor+remainder==dividend and remainder<divisor.
